dm_arbiter: RTL
===============

# dm_arbiter

Arbitrates the single data memory (DM) port between the CPU memory stage and a DMA requester. Sits between the M-stage load/store path, the DMA engine and the DM: it drives the DM address, write-data, byte-enable and write/read-enable inputs. Grant is fixed-priority to the CPU, with a starvation counter that forces a DMA grant after a bounded wait. Read data returns through a registered response path to whichever requester was granted.

## Interface
- `MAX_WAIT`, default 4: consecutive ungranted DMA-request cycles before the DMA is force-granted; legal range 1..15.
- `clk`  in  1  system clock; everything is updated on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU access request; held until granted.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored.
- `cpu_be`  in  4  byte enables for stores; bit i enables byte lane i.
- `cpu_wd`  in  32  store data, already lane-aligned.
- `cpu_gnt`  out  1  combinational grant; the access completes at this edge.
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; freezes the pipeline.
- `cpu_rvalid`  out  1  registered; load data valid.
- `cpu_rd`  out  32  registered load data.
- `dma_req`, `dma_we`, `dma_addr`[32], `dma_be`[4], `dma_wd`[32]: same meaning as the CPU inputs.
- `dma_gnt`, `dma_rvalid`, `dma_rd`[32]: same meaning as the CPU outputs.
- `dm_addr`  out  32  to the DM.
- `dm_wd`  out  32  to the DM.
- `dm_be`  out  4  to the DM.
- `dm_we`  out  1  to the DM.
- `dm_re`  out  1  to the DM.
- `dm_rd`  in  32  from the DM; the DM read is combinational on `dm_addr`.

## Operation
- **Per-cycle grant rule**, evaluated combinationally:
  - If `force_dma = dma_req & (wait_cnt == MAX_WAIT)`: grant DMA.
  - Else if `cpu_req`: grant CPU.
  - Else if `dma_req`: grant DMA.
  - Else: no grant.
- At most one grant per cycle.
- **Granted requester drives the DM:**
  - `dm_addr` = `{addr[31:2],2'b00}`.
  - `dm_wd`, `dm_be` pass through from the granted requester.
  - `dm_we` = `we`.
  - `dm_re` = `~we`.
- **No grant:** `dm_we` = `dm_re` = 0, `dm_be` = 0, `dm_addr`/`dm_wd` = 0.
- **Stores:**
  - The DM writes at the edge closing the grant cycle.
  - A store with `be` = 0 is granted and consumes the cycle; no byte changes.
  - Stores produce no rvalid.
- **Loads:** at the edge closing the grant cycle, `dm_rd` is captured into the granted requester's `rd` register and its `rvalid` is set for exactly one cycle. The other requester's `rd` holds its value.
- **`wait_cnt`** (4-bit, saturating at `MAX_WAIT`):
  - Increments each cycle with `dma_req & ~dma_gnt`.
  - Clears on `dma_gnt` or when `dma_req` = 0.
- **Requester obligations:** keep `req` and all request fields stable until `gnt`. Deasserting `req` before `gnt` withdraws the request.

## Timing
- **Reset values:** all registered outputs 0 (`cpu_rvalid`, `dma_rvalid`, `cpu_rd`, `dma_rd`); `wait_cnt` = 0. Combinational outputs follow the inputs from the first post-reset cycle.
- **Latency:**
  - Grant: 0 cycles (same cycle as `req`) if uncontested.
  - Load data: `rvalid` in the cycle after `gnt`.
  - Back-to-back grants to the same requester are allowed every cycle.
- **CPU blocked by DMA:** `cpu_stall` = 1 for exactly the force-grant cycle, then the CPU is granted the next cycle.
- **Worst-case DMA wait:** `MAX_WAIT` cycles of CPU traffic, then one forced grant. `wait_cnt` resets and the next window starts.
- **Simultaneous first request** (`wait_cnt` = 0): CPU wins. DMA is granted in cycle `MAX_WAIT` + 1 at the latest.
- **Reset during an access:**
  - A store granted in the reset cycle is still presented to the DM (the DM has its own reset).
  - A pending `rvalid` is dropped; no rvalid appears in the cycle after reset.
- **Same address:** CPU and DMA accesses to the same word resolve in grant order; a load sees all stores granted in earlier cycles.

## Structure
- **Shared package `dm_pkg`:**
  - Request-port field widths (`ADDR_W`=32, `DATA_W`=32, `BE_W`=4).
  - Requester ID encoding (`REQ_NONE`=0, `REQ_CPU`=1, `REQ_DMA`=2), used for the registered response steering.
- **Sub-module `dm_arb_starve_cnt`:** the saturating wait counter plus the `force_dma` compare, parameterised by `MAX_WAIT`.
- **Top level:** grant logic, DM muxing, and the one-cycle response register (`resp_id` plus per-requester `rd`/`rvalid`).

## Test plan
1. **Reset then CPU load.** After reset, CPU load to 0x0000_0010 with DM word 0xDEADBEEF:
   - `cpu_gnt` in cycle 0.
   - `dm_addr`=0x10, `dm_re`=1.
   - `cpu_rvalid`=1 and `cpu_rd`=0xDEADBEEF in cycle 1.
   - `dma_rvalid` stays 0.
2. **Simultaneous requests, `MAX_WAIT`=4.** CPU stores every cycle while DMA requests continuously:
   - CPU granted in cycles 0–3.
   - DMA granted in cycle 4, with `cpu_stall`=1 only in cycle 4.
   - CPU granted again in cycle 5.
   - `wait_cnt` back to 0 after cycle 4.
3. **Byte-lane store.** DMA store, addr 0x0000_0022, be=4'b0100, wd=0x00AB0000:
   - `dm_be`=4'b0100, `dm_addr`=0x20, `dm_we`=1, `dm_re`=0.
   - Then a CPU load of 0x20 returns that word with byte 2 = 0xAB.
4. **Zero byte-enable store.** CPU store with be=0:
   - `cpu_gnt`=1, `dm_we`=1, `dm_be`=0.
   - A following load returns the unchanged word.
   - No rvalid in the cycle after the store.
5. **Reset during a load.** Assert `reset` in the grant cycle of a DMA load:
   - `dma_rvalid`=0 and `dma_rd`=0 in the next cycle.
   - `wait_cnt`=0.
   - A new CPU request is granted in the first cycle after reset deasserts.
6. **Withdrawn request.** DMA request withdrawn after 2 ungranted cycles:
   - `wait_cnt` returns to 0.
   - A fresh DMA request must again wait the full `MAX_WAIT`=4 cycles of CPU traffic before its forced grant.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the request-port field widths and the requester ID encoding used to
// steer the registered read response back to the requester that was granted.
package dm_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_DMA  = 2'd2
  } req_id_e;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// DMA starvation counter.
// Counts consecutive cycles in which the DMA requests but is not granted,
// saturating at MAX_WAIT. When the count has reached MAX_WAIT while the DMA
// is still requesting, force_dma tells the grant logic to override the CPU.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   dma_req      DMA is requesting this cycle
//   dma_gnt      DMA was granted this cycle
//   wait_cnt     current count (registered)
//   force_dma    dma_req & (wait_cnt == MAX_WAIT)
module dm_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dma_req,
  input  logic       dma_gnt,
  output logic [3:0] wait_cnt,
  output logic       force_dma
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // A withdrawn request or a grant both start a fresh wait window.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req || dma_gnt) begin
      cnt_d = 4'd0;
    end else if (cnt_q != MaxWait) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on the registered count, so feeding dma_gnt back in above
  // does not form a combinational loop.
  assign force_dma = dma_req && (cnt_q == MaxWait);
  assign wait_cnt  = cnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter between the CPU memory stage and a DMA engine.
// Fixed priority to the CPU, with a starvation counter that forces a DMA
// grant after MAX_WAIT ungranted cycles. Grants are combinational; the
// access completes at the edge closing the grant cycle. Load data returns
// one cycle later through per-requester registers.
// Handshake: a requester holds req and all request fields stable until it
// sees gnt in the same cycle; dropping req before gnt withdraws the request.
// Ports:
//   cpu_*   CPU request (req/we/addr/be/wd) and response (gnt/stall/rvalid/rd)
//   dma_*   DMA request and response, same meaning as the CPU ports
//   dm_*    DM control outputs (addr/wd/be/we/re) and combinational dm_rd
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rd,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [BE_W-1:0]   dma_be,
  input  logic [DATA_W-1:0] dma_wd,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rd,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wd,
  output logic [BE_W-1:0]   dm_be,
  output logic              dm_we,
  output logic              dm_re,
  input  logic [DATA_W-1:0] dm_rd
);

  logic       force_dma;
  logic [3:0] wait_cnt;

  req_id_e           resp_id_q, resp_id_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] dma_rd_q, dma_rd_d;

  // The DM word address drops the byte offset, so these bits are never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], dma_addr[1:0]};

  dm_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .dma_req  (dma_req),
    .dma_gnt  (dma_gnt),
    .wait_cnt (wait_cnt),
    .force_dma(force_dma)
  );

  // Grant does not look at reset: a store granted in the reset cycle still
  // reaches the DM, which has its own reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (force_dma) begin
      dma_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dma_req) begin
      dma_gnt = 1'b1;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    dm_addr = '0;
    dm_wd   = '0;
    dm_be   = '0;
    dm_we   = 1'b0;
    dm_re   = 1'b0;
    if (cpu_gnt) begin
      dm_addr = {cpu_addr[ADDR_W-1:2], 2'b00};
      dm_wd   = cpu_wd;
      dm_be   = cpu_be;
      dm_we   = cpu_we;
      dm_re   = ~cpu_we;
    end else if (dma_gnt) begin
      dm_addr = {dma_addr[ADDR_W-1:2], 2'b00};
      dm_wd   = dma_wd;
      dm_be   = dma_be;
      dm_we   = dma_we;
      dm_re   = ~dma_we;
    end
  end

  // Only loads produce a response; the non-granted requester's rd holds.
  always_comb begin
    resp_id_d = REQ_NONE;
    cpu_rd_d  = cpu_rd_q;
    dma_rd_d  = dma_rd_q;
    if (cpu_gnt && !cpu_we) begin
      resp_id_d = REQ_CPU;
      cpu_rd_d  = dm_rd;
    end else if (dma_gnt && !dma_we) begin
      resp_id_d = REQ_DMA;
      dma_rd_d  = dm_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_id_q <= REQ_NONE;
      cpu_rd_q  <= '0;
      dma_rd_q  <= '0;
    end else begin
      resp_id_q <= resp_id_d;
      cpu_rd_q  <= cpu_rd_d;
      dma_rd_q  <= dma_rd_d;
    end
  end

  assign cpu_rvalid = (resp_id_q == REQ_CPU);
  assign dma_rvalid = (resp_id_q == REQ_DMA);
  assign cpu_rd     = cpu_rd_q;
  assign dma_rd     = dma_rd_q;

endmodule
